mac_row_engine: RTL and testbench
=================================

# mac_row_engine

Parametrised row multiply-accumulate engine for the inference datapath, succeeding the fixed two-lane `multiplier`. On `begin_mult` it streams one image vector and one weight row out of synchronous memories, `LANES` elements per cycle. It forms the signed dot product in a pipelined accumulator and reports a range-checked result with a one-cycle write strobe to the result memory. It sits between the pixel/weight SRAMs and the result buffer and is sequenced by the layer controller.

## Interface
- `LANES`, 2, elements fetched and multiplied per cycle (power of two, 1–8)
- `PIX_W`, 8, unsigned pixel width
- `WGT_W`, 16, two's-complement weight width
- `VEC_LEN`, 784, elements per vector (multiple of `LANES`); `N_WORDS = VEC_LEN/LANES`
- `ROWS`, 10, weight rows available
- `ACC_W`, 32, signed accumulator width
- `OUT_W`, 16, signed result width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `row_select`  in  clog2(ROWS)  weight row; sampled with `begin_mult`
- `begin_mult`  in  1  start request; sampled only in IDLE
- `pixel_value`  in  LANES*PIX_W  pixel word; lane 0 in the MSBs
- `weight_value`  in  LANES*WGT_W  weight word; lane 0 in the MSBs
- `pixel_address`  out  clog2(N_WORDS)  pixel word index
- `weight_address`  out  clog2(ROWS*N_WORDS)  = row*N_WORDS + index
- `busy`  out  1  high in every state except IDLE
- `done_row`  out  1  one-cycle completion pulse
- `row_result`  out  OUT_W  signed dot product
- `overflow`  out  1  result or accumulator out of range for the last row
- `w_result_ena`  out  1  result-memory write strobe; coincident with `done_row`

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- **IDLE → FETCH:** on `begin_mult` with `row_select < ROWS`. This captures the row, clears the accumulator and the sticky overflow, and zeroes the index.
  - `begin_mult` with `row_select >= ROWS` is ignored and the FSM stays in IDLE.
- **FETCH:** issues index 0..N_WORDS-1, one per cycle. After the last index the FSM enters DRAIN.
- **DRAIN:** lasts 2 cycles, to flush the memory and product stages. It then enters DONE.
- **DONE:** lasts 1 cycle. It registers `row_result`/`overflow`, pulses `done_row` and `w_result_ena`, and returns to IDLE.
- `begin_mult` is ignored outside IDLE.
- **Arithmetic per lane:** product = zero-extended pixel × sign-extended weight, PIX_W+WGT_W+1 bits signed. The lane products are summed, then added to the accumulator.
- **Accumulator overflow:** any add whose true sum leaves the ACC_W signed range sets the sticky overflow.
- **Final range check:** an accumulator outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] also sets `overflow`.
- `row_result` and `overflow` hold until the next DONE.
- `rst` at any time returns the FSM to IDLE and aborts any in-flight row with no `done_row` pulse.
- Reset values: every output 0, including the addresses and `row_result`; the accumulator is also 0.

## Timing
- Memories have 1-cycle read latency: data for the address driven after edge i is valid after edge i+1.
- **Pipeline:** memory (edge i+1), product register (edge i+2), accumulator (edge i+3).
- `done_row` is high for exactly the cycle after edge N_WORDS+3, counting the edge that sampled `begin_mult` as edge 0. For the defaults this is edge 395.
- `busy` rises after edge 0 and falls with the exit from DONE.
- A new `begin_mult` may be presented in the cycle `done_row` is high; it is sampled at the following edge, once the FSM is back in IDLE.
- Addresses hold their last value outside FETCH.

## Configuration
- **`MAC_SATURATE_EN` defined:**
  - The accumulator clamps at its ACC_W limits instead of wrapping.
  - An out-of-range `row_result` clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- **Undefined:** both the accumulator and `row_result` wrap; `row_result` is the low OUT_W bits of the accumulator.
- `overflow` behaves identically in both builds.

## Structure
- Package `mac_pkg`:
  - state enum `mac_state_t`
  - default parameter constants
  - saturate/range-check functions
- Sub-module `mac_product_stage`:
  - lane unpacking
  - LANES signed multiplies
  - adder tree
  - product pipeline register
- The top level holds the FSM, address counter, accumulator and output registers.

## Test plan
- All pixels 1, all weights 1, row 0 → `row_result`=784, `overflow`=0; `done_row` high for one cycle 395 edges after begin.
- Weight lane 0 = 1, lane 1 = 0, row 1 → 392, no overflow.
- Weight lane 0 = 16'hFF00 (-256), lane 1 = 0, pixels 1 → `overflow`=1.
  - Saturating build: `row_result`=16'h8000.
  - Wrapping build: 16'h7800.
- Weight lane 0 = 168, pixels 1 → `overflow`=1.
  - Saturating build: `row_result`=32767.
  - Wrapping build: 320.
- `row_select`=3 → first `weight_address`=1176 and last = 1567; `row_select`=10 → ignored, `busy` stays 0.
- Control corner cases:
  - `rst` asserted mid-FETCH → the next cycle is IDLE with all outputs 0 and no `done_row`.
  - `begin_mult` pulsed while `busy` → ignored; exactly one `done_row` is produced.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the row multiply-accumulate engine:
//   - mac_state_t   : controller state encoding (IDLE, FETCH, DRAIN, DONE)
//   - DEF_*         : default parameter values for mac_row_engine
//   - lane_sum_width: width of the summed lane products
//   - range_max / range_min / range_exceeded / saturate : signed range helpers
//     operating on a 64-bit working width (wide_t)
// -----------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_t;

  localparam int unsigned DEF_LANES   = 32'd2;
  localparam int unsigned DEF_PIX_W   = 32'd8;
  localparam int unsigned DEF_WGT_W   = 32'd16;
  localparam int unsigned DEF_VEC_LEN = 32'd784;
  localparam int unsigned DEF_ROWS    = 32'd10;
  localparam int unsigned DEF_ACC_W   = 32'd32;
  localparam int unsigned DEF_OUT_W   = 32'd16;

  // Cycles spent flushing the memory and product stages after the last fetch.
  localparam int unsigned DRAIN_CYCLES = 32'd2;

  // Working width for range arithmetic; wide enough for any legal ACC_W/OUT_W.
  localparam int unsigned WIDE_W = 32'd64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // One lane product is PIX_W+WGT_W+1 bits signed; summing LANES of them
  // grows the result by clog2(LANES) bits.
  function automatic int unsigned lane_sum_width(input int unsigned pix_w,
                                                 input int unsigned wgt_w,
                                                 input int unsigned lanes);
    return pix_w + wgt_w + 32'd1 + $clog2(lanes);
  endfunction

  function automatic wide_t range_max(input int unsigned w);
    return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
  endfunction

  function automatic wide_t range_min(input int unsigned w);
    return -range_max(w) - 64'sd1;
  endfunction

  function automatic logic range_exceeded(input wide_t v, input int unsigned w);
    logic r;
    if ((v > range_max(w)) || (v < range_min(w))) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  function automatic wide_t saturate(input wide_t v, input int unsigned w);
    wide_t r;
    if (v > range_max(w)) begin
      r = range_max(w);
    end else if (v < range_min(w)) begin
      r = range_min(w);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_product_stage.sv
// -----------------------------------------------------------------------------
// mac_product_stage
// Unpacks LANES pixel/weight pairs from the memory words, multiplies each pair
// (zero-extended pixel x sign-extended weight), sums the lane products in a
// binary adder tree and registers the sum together with its valid flag.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : pixel_word/weight_word carry a fetched element pair
//   pixel_word   : LANES x PIX_W unsigned pixels, lane 0 in the MSBs
//   weight_word  : LANES x WGT_W signed weights, lane 0 in the MSBs
//   out_valid    : prod_sum holds a new lane sum this cycle
//   prod_sum     : registered signed sum of the lane products
// -----------------------------------------------------------------------------
module mac_product_stage
  import mac_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned WGT_W = DEF_WGT_W,
  parameter int unsigned SUM_W = lane_sum_width(DEF_PIX_W, DEF_WGT_W, DEF_LANES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [LANES*PIX_W-1:0]         pixel_word,
  input  logic [LANES*WGT_W-1:0]         weight_word,
  output logic                           out_valid,
  output logic signed [SUM_W-1:0]        prod_sum
);

  localparam int unsigned PROD_W = PIX_W + WGT_W + 32'd1;

  logic signed [PROD_W-1:0] lane_prod_s [LANES];
  // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, root at index 0.
  logic signed [SUM_W-1:0]  node_s      [2*LANES-1];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PIX_W-1:0]        pix_s;
    logic signed [WGT_W-1:0] wgt_s;

    assign pix_s = pixel_word[(LANES-1-l)*PIX_W +: PIX_W];
    assign wgt_s = weight_word[(LANES-1-l)*WGT_W +: WGT_W];
    // The extra zero bit keeps the pixel non-negative in the signed multiply.
    assign lane_prod_s[l] = PROD_W'($signed({1'b0, pix_s})) * PROD_W'(wgt_s);
  end

  // Adder tree: each internal node sums its two children.
  always_comb begin
    for (int n = 0; n < 2*LANES-1; n++) begin
      node_s[n] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      node_s[LANES-1+l] = SUM_W'(lane_prod_s[l]);
    end
    for (int n = LANES-2; n >= 0; n--) begin
      node_s[n] = node_s[2*n+1] + node_s[2*n+2];
    end
  end

  // Product pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      prod_sum  <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      prod_sum  <= node_s[0];
    end else begin
      out_valid <= 1'b0;
      prod_sum  <= prod_sum;
    end
  end

endmodule

// File: rtl/mac_row_engine.sv
// -----------------------------------------------------------------------------
// mac_row_engine
// Streams one pixel vector and one weight row from synchronous memories,
// LANES elements per cycle, accumulates the signed dot product and reports a
// range-checked result with a one-cycle write strobe.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset (aborts any row)
//   row_select      : weight row, sampled with begin_mult
//   begin_mult      : start request, honoured only in IDLE with a valid row
//   pixel_value     : pixel memory read data (lane 0 in the MSBs)
//   weight_value    : weight memory read data (lane 0 in the MSBs)
//   pixel_address   : pixel word index
//   weight_address  : row*N_WORDS + word index
//   busy            : high outside IDLE
//   done_row        : one-cycle completion pulse
//   row_result      : signed dot product of the last row
//   overflow        : accumulator or result range violation for the last row
//   w_result_ena    : result-memory write strobe, coincident with done_row
//
// Build option: MAC_SATURATE_EN clamps the accumulator and row_result instead
// of wrapping; overflow reporting is the same in both builds.
//
// Pipeline (edge 0 samples begin_mult): address issued after edge i, memory
// data after i+1, product register after i+2, accumulator after i+3. The last
// accumulate happens at edge N_WORDS+2 and DONE publishes at edge N_WORDS+3.
// -----------------------------------------------------------------------------
module mac_row_engine
  import mac_pkg::*;
#(
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned PIX_W   = DEF_PIX_W,
  parameter int unsigned WGT_W   = DEF_WGT_W,
  parameter int unsigned VEC_LEN = DEF_VEC_LEN,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned OUT_W   = DEF_OUT_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [$clog2(ROWS)-1:0]                  row_select,
  input  logic                                     begin_mult,
  input  logic [LANES*PIX_W-1:0]                   pixel_value,
  input  logic [LANES*WGT_W-1:0]                   weight_value,
  output logic [$clog2(VEC_LEN/LANES)-1:0]         pixel_address,
  output logic [$clog2(ROWS*(VEC_LEN/LANES))-1:0]  weight_address,
  output logic                                     busy,
  output logic                                     done_row,
  output logic signed [OUT_W-1:0]                  row_result,
  output logic                                     overflow,
  output logic                                     w_result_ena
);

  localparam int unsigned N_WORDS = VEC_LEN / LANES;
  localparam int unsigned PA_W    = $clog2(N_WORDS);
  localparam int unsigned WA_W    = $clog2(ROWS * N_WORDS);
  localparam int unsigned SUM_W   = lane_sum_width(PIX_W, WGT_W, LANES);

`ifdef MAC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  mac_state_t              state_r;
  logic                    drain_cnt_r;
  logic                    mem_valid_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    acc_ovf_r;

  logic                    start_s;
  logic [WA_W-1:0]         start_base_s;
  logic                    prod_valid_s;
  logic signed [SUM_W-1:0] prod_sum_s;
  wide_t                   acc_wide_s;
  wide_t                   acc_true_s;
  logic                    add_ovf_s;
  logic                    res_ovf_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic [OUT_W-1:0]        res_next_s;

  // Out-of-range rows are dropped here so the FSM never leaves IDLE for them.
  assign start_s      = (state_r == ST_IDLE) && begin_mult &&
                        (32'(row_select) < ROWS);
  assign start_base_s = WA_W'(row_select) * WA_W'(N_WORDS);

  mac_product_stage #(
    .LANES (LANES),
    .PIX_W (PIX_W),
    .WGT_W (WGT_W),
    .SUM_W (SUM_W)
  ) u_product (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (mem_valid_r),
    .pixel_word  (pixel_value),
    .weight_word (weight_value),
    .out_valid   (prod_valid_s),
    .prod_sum    (prod_sum_s)
  );

  // Next accumulator value, add overflow, and the range-checked result.
  always_comb begin
    acc_wide_s = WIDE_W'(acc_r);
    acc_true_s = acc_wide_s + WIDE_W'(prod_sum_s);
    add_ovf_s  = range_exceeded(acc_true_s, ACC_W);
    res_ovf_s  = range_exceeded(acc_wide_s, OUT_W);
    if (SAT_EN) begin
      acc_next_s = ACC_W'(saturate(acc_true_s, ACC_W));
      res_next_s = OUT_W'(saturate(acc_wide_s, OUT_W));
    end else begin
      acc_next_s = ACC_W'(acc_true_s);
      res_next_s = OUT_W'(acc_r);
    end
  end

  // Memory read-data valid: one cycle behind each issued address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_r <= 1'b0;
    end else begin
      mem_valid_r <= (state_r == ST_FETCH);
    end
  end

  // Accumulator with sticky add-overflow; cleared when a row is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      acc_ovf_r <= 1'b0;
    end else if (start_s) begin
      acc_r     <= '0;
      acc_ovf_r <= 1'b0;
    end else if (prod_valid_s) begin
      acc_r     <= acc_next_s;
      acc_ovf_r <= acc_ovf_r | add_ovf_s;
    end else begin
      acc_r     <= acc_r;
      acc_ovf_r <= acc_ovf_r;
    end
  end

  // Controller FSM with address counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      drain_cnt_r    <= 1'b0;
      pixel_address  <= '0;
      weight_address <= '0;
      busy           <= 1'b0;
      done_row       <= 1'b0;
      w_result_ena   <= 1'b0;
      row_result     <= '0;
      overflow       <= 1'b0;
    end else begin
      done_row     <= 1'b0;
      w_result_ena <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r        <= ST_FETCH;
            busy           <= 1'b1;
            pixel_address  <= '0;
            weight_address <= start_base_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          // Addresses stop on the last word and hold until the next row.
          if (pixel_address == PA_W'(N_WORDS - 32'd1)) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= 1'b0;
          end else begin
            pixel_address  <= pixel_address + PA_W'(1);
            weight_address <= weight_address + WA_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 1'(DRAIN_CYCLES - 32'd1)) begin
            state_r <= ST_DONE;
          end else begin
            drain_cnt_r <= drain_cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          row_result   <= res_next_s;
          overflow     <= acc_ovf_r | res_ovf_s;
          done_row     <= 1'b1;
          w_result_ena <= 1'b1;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_row_engine.sv
// -----------------------------------------------------------------------------
// tb_mac_row_engine
// Self-checking bench for mac_row_engine (default parameters). Models the
// pixel/weight SRAMs with 1-cycle read latency, pushes the expected result of
// every accepted row into a scoreboard queue and checks it on done_row.
// -----------------------------------------------------------------------------
module tb_mac_row_engine;

  localparam int LANES   = 2;
  localparam int PIX_W   = 8;
  localparam int WGT_W   = 16;
  localparam int VEC_LEN = 784;
  localparam int ROWS    = 10;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int N_WORDS = VEC_LEN / LANES;
  localparam int PA_W    = $clog2(N_WORDS);
  localparam int WA_W    = $clog2(ROWS * N_WORDS);
  localparam int RS_W    = $clog2(ROWS);
  localparam int LAT     = N_WORDS + 3;

`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] res;
    logic             ovf;
  } exp_t;

  logic                    tb_clk = 1'b0;
  logic                    rst;
  logic [RS_W-1:0]         row_select;
  logic                    begin_mult;
  logic [LANES*PIX_W-1:0]  pixel_value;
  logic [LANES*WGT_W-1:0]  weight_value;
  logic [PA_W-1:0]         pixel_address;
  logic [WA_W-1:0]         weight_address;
  logic                    busy;
  logic                    done_row;
  logic [OUT_W-1:0]        row_result;
  logic                    overflow;
  logic                    w_result_ena;

  logic [LANES*PIX_W-1:0]  pmem [N_WORDS];
  logic [LANES*WGT_W-1:0]  wmem [ROWS*N_WORDS];

  exp_t             sb_q[$];
  int               tests_run    = 0;
  int               tests_failed = 0;
  int               edge_cnt     = 0;
  int               begin_edge   = 0;
  logic [OUT_W-1:0] last_res     = '0;

  mac_row_engine dut (
    .clk            (tb_clk),
    .rst            (rst),
    .row_select     (row_select),
    .begin_mult     (begin_mult),
    .pixel_value    (pixel_value),
    .weight_value   (weight_value),
    .pixel_address  (pixel_address),
    .weight_address (weight_address),
    .busy           (busy),
    .done_row       (done_row),
    .row_result     (row_result),
    .overflow       (overflow),
    .w_result_ena   (w_result_ena)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) edge_cnt <= edge_cnt + 1;

  // Synchronous memories, 1-cycle read latency.
  always @(posedge tb_clk) begin
    pixel_value  <= pmem[pixel_address];
    weight_value <= wmem[weight_address];
  end

  // Reference dot product with per-add accumulator range handling.
  function automatic exp_t model_row(input int row);
    longint acc_hi, acc_lo, out_hi, out_lo, acc, s, t;
    logic [LANES*PIX_W-1:0] pw;
    logic [LANES*WGT_W-1:0] ww;
    logic [PIX_W-1:0] p;
    logic signed [WGT_W-1:0] w;
    exp_t e;
    acc_hi = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    acc_lo = -acc_hi - 64'sd1;
    out_hi = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    out_lo = -out_hi - 64'sd1;
    acc = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < N_WORDS; i++) begin
      pw = pmem[i];
      ww = wmem[row*N_WORDS + i];
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        p = pw[(LANES-1-l)*PIX_W +: PIX_W];
        w = ww[(LANES-1-l)*WGT_W +: WGT_W];
        s = s + longint'(p) * longint'(w);
      end
      t = acc + s;
      if (t > acc_hi || t < acc_lo) begin
        e.ovf = 1'b1;
        if (SAT) t = (t > 0) ? acc_hi : acc_lo;
        else     t = longint'(int'(t));
      end
      acc = t;
    end
    if (acc > out_hi || acc < out_lo) begin
      e.ovf = 1'b1;
      if (SAT) e.res = (acc > 0) ? 16'h7FFF : 16'h8000;
      else     e.res = acc[OUT_W-1:0];
    end else begin
      e.res = acc[OUT_W-1:0];
    end
    return e;
  endfunction

  task automatic fill_const(input logic [PIX_W-1:0] pix,
                            input logic [WGT_W-1:0] w0,
                            input logic [WGT_W-1:0] w_rest);
    logic [LANES*PIX_W-1:0] pw;
    logic [LANES*WGT_W-1:0] ww;
    for (int l = 0; l < LANES; l++) begin
      pw[(LANES-1-l)*PIX_W +: PIX_W] = pix;
      ww[(LANES-1-l)*WGT_W +: WGT_W] = (l == 0) ? w0 : w_rest;
    end
    for (int i = 0; i < N_WORDS; i++) pmem[i] = pw;
    for (int i = 0; i < ROWS*N_WORDS; i++) wmem[i] = ww;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_WORDS; i++) pmem[i] = (LANES*PIX_W)'($urandom);
    for (int i = 0; i < ROWS*N_WORDS; i++) wmem[i] = (LANES*WGT_W)'($urandom);
  endtask

  // Presents begin_mult for one cycle; returns at the negedge after edge 0.
  task automatic start_row(input int row, input bit push);
    @(negedge tb_clk);
    row_select = RS_W'(row);
    begin_mult = 1'b1;
    begin_edge = edge_cnt + 1;
    if (push) sb_q.push_back(model_row(row));
    @(negedge tb_clk);
    begin_mult = 1'b0;
  endtask

  // Waits for done_row, checks latency and the scoreboard entry. With
  // chain_row >= 0 a new begin_mult is presented in the done_row cycle.
  task automatic wait_result(input string name, input int chain_row);
    exp_t e;
    int c = 0;
    while (done_row !== 1'b1 && c < LAT + 20) begin
      @(negedge tb_clk);
      c++;
    end
    tests_run++;
    if (done_row !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: done_row not seen after %0d cycles", name, c);
    end else begin
      tests_run++;
      if (edge_cnt - begin_edge !== LAT) begin
        tests_failed++;
        $display("FAIL %s_latency: got %0d expected %0d", name, edge_cnt - begin_edge, LAT);
      end
      tests_run++;
      if (w_result_ena !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_wena: got %b expected 1", name, w_result_ena);
      end
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL %s_sb_empty: got done_row with no expected result", name);
      end else begin
        e = sb_q.pop_front();
        last_res = e.res;
        if (row_result !== e.res) begin
          tests_failed++;
          $display("FAIL %s_result: got %h expected %h", name, row_result, e.res);
        end
        tests_run++;
        if (overflow !== e.ovf) begin
          tests_failed++;
          $display("FAIL %s_overflow: got %b expected %b", name, overflow, e.ovf);
        end
      end
      if (chain_row >= 0) begin
        row_select = RS_W'(chain_row);
        begin_mult = 1'b1;
        begin_edge = edge_cnt + 1;
        sb_q.push_back(model_row(chain_row));
      end
      @(negedge tb_clk);
      begin_mult = 1'b0;
      tests_run++;
      if (done_row !== 1'b0 || w_result_ena !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_pulse_width: done_row %b w_result_ena %b expected 0 0", name, done_row, w_result_ena);
      end
      tests_run++;
      if (busy !== (chain_row >= 0)) begin
        tests_failed++;
        $display("FAIL %s_busy_after: got %b expected %b", name, busy, chain_row >= 0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    begin_mult = 1'b0;
    row_select = '0;
    repeat (3) @(negedge tb_clk);
    tests_run++;
    if (busy !== 1'b0 || done_row !== 1'b0 || w_result_ena !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy %b done %b wena %b ovf %b expected all 0", busy, done_row, w_result_ena, overflow);
    end
    tests_run++;
    if (row_result !== '0 || pixel_address !== '0 || weight_address !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: result %h paddr %0d waddr %0d expected 0", row_result, pixel_address, weight_address);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    fill_const(8'd1, 16'd1, 16'd1);
    start_row(0, 1'b1);
    wait_result("all_ones", -1);
    tests_run++;
    if (last_res !== 16'd784) begin
      tests_failed++;
      $display("FAIL all_ones_value: got %0d expected 784", last_res);
    end
  endtask

  task automatic test_lane0_only();
    fill_const(8'd1, 16'd1, 16'd0);
    start_row(1, 1'b1);
    wait_result("lane0_only", -1);
    tests_run++;
    if (last_res !== 16'd392) begin
      tests_failed++;
      $display("FAIL lane0_only_value: got %0d expected 392", last_res);
    end
  endtask

  task automatic test_neg_overflow();
    fill_const(8'd1, 16'hFF00, 16'd0);
    start_row(2, 1'b1);
    wait_result("neg_overflow", -1);
    tests_run++;
    if (last_res !== (SAT ? 16'h8000 : 16'h7800) || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL neg_overflow_value: got %h/%b expected %h/1", row_result, overflow, SAT ? 16'h8000 : 16'h7800);
    end
  endtask

  task automatic test_pos_overflow();
    fill_const(8'd1, 16'd168, 16'd0);
    start_row(4, 1'b1);
    wait_result("pos_overflow", -1);
    tests_run++;
    if (last_res !== (SAT ? 16'd32767 : 16'd320) || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL pos_overflow_value: got %0d/%b expected %0d/1", row_result, overflow, SAT ? 32767 : 320);
    end
  endtask

  task automatic test_acc_overflow();
    fill_const(8'd255, 16'h7FFF, 16'h7FFF);
    start_row(9, 1'b1);
    wait_result("acc_overflow", -1);
  endtask

  task automatic test_row_address();
    fill_const(8'd2, 16'hFFFD, 16'd7);
    start_row(3, 1'b1);
    tests_run++;
    if (weight_address !== 12'd1176 || pixel_address !== '0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL row_addr_first: waddr %0d paddr %0d busy %b expected 1176 0 1", weight_address, pixel_address, busy);
    end
    repeat (N_WORDS - 1) @(negedge tb_clk);
    tests_run++;
    if (weight_address !== 12'd1567 || pixel_address !== 9'd391) begin
      tests_failed++;
      $display("FAIL row_addr_last: waddr %0d paddr %0d expected 1567 391", weight_address, pixel_address);
    end
    wait_result("row3", -1);
  endtask

  task automatic test_bad_row();
    int busy_hi = 0;
    int dones = 0;
    start_row(10, 1'b0);
    repeat (20) begin
      if (busy === 1'b1) busy_hi++;
      if (done_row === 1'b1) dones++;
      @(negedge tb_clk);
    end
    tests_run++;
    if (busy_hi !== 0 || dones !== 0) begin
      tests_failed++;
      $display("FAIL bad_row_ignored: busy cycles %0d done pulses %0d expected 0 0", busy_hi, dones);
    end
    tests_run++;
    if (row_result !== last_res || pixel_address !== 9'd391 || weight_address !== 12'd1567) begin
      tests_failed++;
      $display("FAIL bad_row_hold: result %h paddr %0d waddr %0d expected %h 391 1567", row_result, pixel_address, weight_address, last_res);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    fill_const(8'd3, 16'd5, 16'd9);
    start_row(5, 1'b0);
    repeat (50) @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done_row !== 1'b0 || w_result_ena !== 1'b0 || overflow !== 1'b0 ||
        row_result !== '0 || pixel_address !== '0 || weight_address !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: busy %b done %b wena %b ovf %b res %h paddr %0d waddr %0d expected all 0",
               busy, done_row, w_result_ena, overflow, row_result, pixel_address, weight_address);
    end
    repeat (LAT + 10) begin
      if (done_row === 1'b1) dones++;
      @(negedge tb_clk);
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    fill_random();
    start_row(0, 1'b1);
    repeat (10) @(negedge tb_clk);
    row_select = RS_W'(2);
    begin_mult = 1'b1;
    @(negedge tb_clk);
    begin_mult = 1'b0;
    wait_result("b2b_first", 7);
    wait_result("b2b_second", -1);
    repeat (20) begin
      if (done_row === 1'b1) dones++;
      @(negedge tb_clk);
    end
    tests_run++;
    if (dones !== 0 || sb_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_extra: extra done pulses %0d pending results %0d expected 0 0", dones, sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    begin_mult = 1'b0;
    row_select = '0;
    fill_const(8'd0, 16'd0, 16'd0);
    test_reset();
    test_all_ones();
    test_lane0_only();
    test_neg_overflow();
    test_pos_overflow();
    test_acc_overflow();
    test_row_address();
    test_bad_row();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
